// File: rtl/load_store_buffer_pkg.sv
// Shared types and constants for the load/store buffer.
// Optional feature macro: LSB_CDB_BYPASS_EN (see load_store_buffer.sv).
package load_store_buffer_pkg;

    localparam int ROB_W = 5;
    typedef logic [ROB_W-1:0] ROB_ID_TYPE;
    localparam ROB_ID_TYPE ZERO_ROB = '0;

    typedef logic [31:0] DATA_TYPE;
    typedef logic [31:0] ADDR_TYPE;

    localparam int LSB_SIZE = 16;
    localparam int LSB_POS_W = $clog2(LSB_SIZE);
    typedef logic [LSB_POS_W-1:0] LSB_POS_TYPE;
    typedef logic [LSB_POS_W:0]   LSB_CNT_TYPE;

    // op = {is_store, signed, size[1:0]}
    typedef logic [3:0] OP_TYPE;
    localparam int OP_STORE_BIT = 3;

    // Loads at or above this address are memory-mapped IO.
    localparam ADDR_TYPE IO_BASE = 32'h30000;

    typedef struct packed {
        logic       busy;
        OP_TYPE     op;
        ROB_ID_TYPE q1;
        DATA_TYPE   v1;
        ROB_ID_TYPE q2;
        DATA_TYPE   v2;
        DATA_TYPE   imm;
        ROB_ID_TYPE rob_id;
        logic       committed;
    } lsb_entry_t;

endpackage

// File: rtl/load_store_buffer_snoop.sv
// One Q/V operand pair snooping the ALU and LSU CDB ports.
// Optional feature macro: none.
module lsb_operand_snoop
    import load_store_buffer_pkg::*;
(
    input  logic       en,
    input  ROB_ID_TYPE q_i,
    input  DATA_TYPE   v_i,
    input  logic       alu_vld,
    input  ROB_ID_TYPE alu_id,
    input  DATA_TYPE   alu_val,
    input  logic       lsu_vld,
    input  ROB_ID_TYPE lsu_id,
    input  DATA_TYPE   lsu_val,
    output ROB_ID_TYPE q_o,
    output DATA_TYPE   v_o
);

    logic pend;
    logic alu_hit;
    logic lsu_hit;

    assign pend    = en && (q_i != ZERO_ROB);
    assign alu_hit = pend && alu_vld && (alu_id == q_i);
    assign lsu_hit = pend && lsu_vld && (lsu_id == q_i);

    // Take the broadcast value when the producer tag matches.
    always_comb begin
        q_o = q_i;
        v_o = v_i;
        if (alu_hit) begin
            q_o = ZERO_ROB;
            v_o = alu_val;
        end else if (lsu_hit) begin
            q_o = ZERO_ROB;
            v_o = lsu_val;
        end
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue between dispatcher and LSU.
// Optional feature macro: LSB_CDB_BYPASS_EN (same-cycle CDB capture on alloc).
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int FULL_MARGIN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       alloc_signal_from_dispatcher,
    input  logic [3:0] op_from_dispatcher,
    input  logic [4:0] Q1_from_dispatcher,
    input  logic [4:0] Q2_from_dispatcher,
    input  logic [31:0] V1_from_dispatcher,
    input  logic [31:0] V2_from_dispatcher,
    input  logic [31:0] imm_from_dispatcher,
    input  logic [4:0] rob_id_from_dispatcher,
    input  logic       update_signal_from_alu,
    input  logic [4:0] rob_id_from_alu,
    input  logic [31:0] result_from_alu,
    input  logic       update_signal_from_lsu,
    input  logic [4:0] rob_id_from_lsu,
    input  logic [31:0] result_from_lsu,
    input  logic       commit_flag_from_rob,
    input  logic [4:0] rob_id_from_rob,
    input  logic [4:0] io_rob_id_from_rob,
    input  logic       misbranch_flag,
    input  logic       lsu_busy,
    output logic       enable_to_lsu,
    output logic [3:0] op_to_lsu,
    output logic [31:0] addr_to_lsu,
    output logic [31:0] data_to_lsu,
    output logic [4:0] rob_id_to_lsu,
    output logic [4:0] io_ins_rob_id_to_rob,
    output logic       full_signal
);

    lsb_entry_t  ent_q [LSB_SIZE];
    lsb_entry_t  ent_d [LSB_SIZE];
    LSB_POS_TYPE head_q, head_d;
    LSB_POS_TYPE tail_q, tail_d;
    LSB_CNT_TYPE count_q, count_d;
    LSB_CNT_TYPE ccnt_q, ccnt_d;

    logic       enable_q, enable_d;
    OP_TYPE     op_q, op_d;
    ADDR_TYPE   addr_q, addr_d;
    DATA_TYPE   data_q, data_d;
    ROB_ID_TYPE rid_q, rid_d;

    ROB_ID_TYPE snp_q1 [LSB_SIZE];
    ROB_ID_TYPE snp_q2 [LSB_SIZE];
    DATA_TYPE   snp_v1 [LSB_SIZE];
    DATA_TYPE   snp_v2 [LSB_SIZE];

    for (genvar i = 0; i < LSB_SIZE; i++) begin : g_snoop
        lsb_operand_snoop u_op1 (
            .en      (ent_q[i].busy),
            .q_i     (ent_q[i].q1),
            .v_i     (ent_q[i].v1),
            .alu_vld (update_signal_from_alu),
            .alu_id  (rob_id_from_alu),
            .alu_val (result_from_alu),
            .lsu_vld (update_signal_from_lsu),
            .lsu_id  (rob_id_from_lsu),
            .lsu_val (result_from_lsu),
            .q_o     (snp_q1[i]),
            .v_o     (snp_v1[i])
        );
        lsb_operand_snoop u_op2 (
            .en      (ent_q[i].busy),
            .q_i     (ent_q[i].q2),
            .v_i     (ent_q[i].v2),
            .alu_vld (update_signal_from_alu),
            .alu_id  (rob_id_from_alu),
            .alu_val (result_from_alu),
            .lsu_vld (update_signal_from_lsu),
            .lsu_id  (rob_id_from_lsu),
            .lsu_val (result_from_lsu),
            .q_o     (snp_q2[i]),
            .v_o     (snp_v2[i])
        );
    end

    ROB_ID_TYPE new_q1, new_q2;
    DATA_TYPE   new_v1, new_v2;

`ifdef LSB_CDB_BYPASS_EN
    lsb_operand_snoop u_byp1 (
        .en      (alloc_signal_from_dispatcher),
        .q_i     (Q1_from_dispatcher),
        .v_i     (V1_from_dispatcher),
        .alu_vld (update_signal_from_alu),
        .alu_id  (rob_id_from_alu),
        .alu_val (result_from_alu),
        .lsu_vld (update_signal_from_lsu),
        .lsu_id  (rob_id_from_lsu),
        .lsu_val (result_from_lsu),
        .q_o     (new_q1),
        .v_o     (new_v1)
    );
    lsb_operand_snoop u_byp2 (
        .en      (alloc_signal_from_dispatcher),
        .q_i     (Q2_from_dispatcher),
        .v_i     (V2_from_dispatcher),
        .alu_vld (update_signal_from_alu),
        .alu_id  (rob_id_from_alu),
        .alu_val (result_from_alu),
        .lsu_vld (update_signal_from_lsu),
        .lsu_id  (rob_id_from_lsu),
        .lsu_val (result_from_lsu),
        .q_o     (new_q2),
        .v_o     (new_v2)
    );
`else
    // Without bypass a same-cycle broadcast is missed here;
    // the dispatcher resolves it from the ROB instead.
    assign new_q1 = Q1_from_dispatcher;
    assign new_v1 = V1_from_dispatcher;
    assign new_q2 = Q2_from_dispatcher;
    assign new_v2 = V2_from_dispatcher;
`endif

    lsb_entry_t hd;
    ADDR_TYPE   hd_addr;
    logic       hd_store;
    logic       hd_io;
    logic       cand;
    logic       issue;

    assign hd       = ent_q[head_q];
    assign hd_addr  = hd.v1 + hd.imm;
    assign hd_store = hd.op[OP_STORE_BIT];
    assign hd_io    = hd.busy && !hd_store
                   && (hd.q1 == ZERO_ROB)
                   && (hd_addr >= IO_BASE);

    // Head-only issue readiness; IO loads wait for the ROB head.
    always_comb begin
        cand = 1'b0;
        if (hd.busy) begin
            unique case (1'b1)
                hd_store: cand = (hd.q1 == ZERO_ROB)
                              && (hd.q2 == ZERO_ROB)
                              && hd.committed;
                hd_io:    cand = (io_rob_id_from_rob == hd.rob_id);
                default:  cand = (hd.q1 == ZERO_ROB);
            endcase
        end
    end

    // During a flush only a committed store may leave.
    assign issue = cand && !lsu_busy
                && (!misbranch_flag || hd_store);

    logic [LSB_SIZE-1:0] cmt_hit;

    // Store commit match; ignored in the flush cycle.
    always_comb begin
        cmt_hit = '0;
        for (int i = 0; i < LSB_SIZE; i++) begin
            cmt_hit[i] = commit_flag_from_rob
                      && !misbranch_flag
                      && ent_q[i].busy
                      && ent_q[i].op[OP_STORE_BIT]
                      && !ent_q[i].committed
                      && (ent_q[i].rob_id == rob_id_from_rob);
        end
    end

    // Queue next-state: snoop, commit, issue, flush, alloc.
    always_comb begin
        ent_d    = ent_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        ccnt_d   = ccnt_q;
        enable_d = 1'b0;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rid_d    = rid_q;

        for (int i = 0; i < LSB_SIZE; i++) begin
            ent_d[i].q1 = snp_q1[i];
            ent_d[i].v1 = snp_v1[i];
            ent_d[i].q2 = snp_q2[i];
            ent_d[i].v2 = snp_v2[i];
            if (cmt_hit[i]) ent_d[i].committed = 1'b1;
        end

        if (issue) begin
            ent_d[head_q] = '0;
            head_d   = head_q + LSB_POS_TYPE'(1);
            enable_d = 1'b1;
            op_d     = hd.op;
            addr_d   = hd_addr;
            data_d   = hd.v2;
            rid_d    = hd.rob_id;
        end

        if (misbranch_flag) begin
            // Committed stores sit contiguously from head.
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (!ent_q[i].committed) ent_d[i] = '0;
            end
            tail_d  = head_q + LSB_POS_TYPE'(ccnt_q);
            count_d = ccnt_q - LSB_CNT_TYPE'(issue);
            ccnt_d  = ccnt_q - LSB_CNT_TYPE'(issue);
        end else begin
            if (alloc_signal_from_dispatcher) begin
                ent_d[tail_q] = '{
                    busy:      1'b1,
                    op:        op_from_dispatcher,
                    q1:        new_q1,
                    v1:        new_v1,
                    q2:        new_q2,
                    v2:        new_v2,
                    imm:       imm_from_dispatcher,
                    rob_id:    rob_id_from_dispatcher,
                    committed: 1'b0
                };
                tail_d = tail_q + LSB_POS_TYPE'(1);
            end
            count_d = count_q
                    + LSB_CNT_TYPE'(alloc_signal_from_dispatcher)
                    - LSB_CNT_TYPE'(issue);
            ccnt_d  = ccnt_q
                    + LSB_CNT_TYPE'(|cmt_hit)
                    - LSB_CNT_TYPE'(issue && hd_store);
        end
    end

    // State register; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LSB_SIZE; i++) ent_q[i] <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ccnt_q   <= '0;
            enable_q <= 1'b0;
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rid_q    <= '0;
        end else if (rdy) begin
            ent_q    <= ent_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ccnt_q   <= ccnt_d;
            enable_q <= enable_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rid_q    <= rid_d;
        end
    end

    assign enable_to_lsu = enable_q;
    assign op_to_lsu     = op_q;
    assign addr_to_lsu   = addr_q;
    assign data_to_lsu   = data_q;
    assign rob_id_to_lsu = rid_q;

    assign io_ins_rob_id_to_rob = hd_io ? hd.rob_id : ZERO_ROB;

    assign full_signal = count_q
        >= LSB_CNT_TYPE'(LSB_SIZE - FULL_MARGIN);

endmodule

// File: doc/load_store_buffer.md
Name: load_store_buffer

Overview:
- In-order memory-op queue between the dispatcher and the load/store unit (LSU) of the Tomasulo RISC-V core.
- Receives load/store entries at dispatch and resolves their operands by snooping the ALU and LSU CDB broadcasts.
- Receives store-commit notices from the reorder buffer (ROB) and issues one memory op at a time, from the head, to the LSU.
- It is the receiving end of the ROB's commit/IO ports: it consumes the commit notice and the ROB-head id, and it produces the IO-instruction rob id back to the ROB.

Parameters:
- LSB_SIZE, 16, number of entries (power of two).
- FULL_MARGIN, 6, full_signal asserts when count >= LSB_SIZE-FULL_MARGIN.
- IO_BASE, 32'h30000, loads with address >= IO_BASE are memory-mapped IO.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- alloc_signal_from_dispatcher  in  1  push one entry.
- op_from_dispatcher  in  4  {is_store, signed, size[1:0]}; size 0=B, 1=H, 2=W.
- Q1_from_dispatcher, Q2_from_dispatcher  in  5 each  producer rob id; 0 = value valid.
- V1_from_dispatcher, V2_from_dispatcher  in  32 each  base and store data.
- imm_from_dispatcher  in  32  offset.
- rob_id_from_dispatcher  in  5  owning rob id (1..16).
- update_signal_from_alu  in  1  ALU CDB broadcast valid.
- rob_id_from_alu  in  5  ALU CDB rob id.
- result_from_alu  in  32  ALU CDB value.
- update_signal_from_lsu  in  1  LSU CDB broadcast valid.
- rob_id_from_lsu  in  5  LSU CDB rob id.
- result_from_lsu  in  32  LSU CDB value.
- commit_flag_from_rob  in  1  commit pulse.
- rob_id_from_rob  in  5  committed rob id.
- io_rob_id_from_rob  in  5  rob id at ROB head if flagged IO, else 0.
- misbranch_flag  in  1  flush.
- lsu_busy  in  1  LSU cannot accept.
- enable_to_lsu  out  1  one-cycle issue pulse.
- op_to_lsu  out  4  issued op.
- addr_to_lsu  out  32  V1+imm.
- data_to_lsu  out  32  store data.
- rob_id_to_lsu  out  5  issued rob id.
- io_ins_rob_id_to_rob  out  5  head IO load's rob id, else 0 (combinational).
- full_signal  out  1  backpressure to dispatcher.

Behaviour:
- Circular queue with head, tail, and count. Per entry: busy, op, Q1/V1, Q2/V2, imm, rob_id, committed.
- Reset (and rdy low): rst clears all entries, head, tail, count, and committed_cnt. Registered outputs reset to 0; io_ins_rob_id_to_rob evaluates to 0.
- Alloc: writes entry[tail] with committed=0; tail wraps at LSB_SIZE-1 to 0. Dispatcher never allocates while full_signal is high.
- Snoop: every cycle, each busy entry with Qx == broadcast rob id (nonzero) takes Vx <= result and Qx <= 0. ALU and LSU are checked independently, so both can resolve in the same cycle.
- Commit: when commit_flag_from_rob is high and rob_id_from_rob matches a busy store, that entry sets committed=1 and committed_cnt increments.
- Issue candidate is the head entry only (memory order kept). Conditions:
  - Store: Q1==0, Q2==0, and committed.
  - Non-IO load: Q1==0.
  - IO load (Q1==0 and V1+imm >= IO_BASE): io_ins_rob_id_to_rob = rob_id; issue only when io_rob_id_from_rob == rob_id.
- Issue: when the candidate is valid and !lsu_busy, pulse enable_to_lsu for one cycle with registered op/addr/data/rob_id. The entry is freed and head advances on the same edge. If the issued entry is a committed store, committed_cnt decrements. Throughput is at most one op per cycle.
- count updates as count + alloc - issue; simultaneous alloc and issue is legal, including when count==1.
- Misbranch (higher priority than alloc; no load issues that cycle):
  - All uncommitted entries are cleared.
  - Committed stores are kept; they are contiguous from head, so tail <= head + committed_cnt (mod LSB_SIZE) and count <= committed_cnt.
  - A committed store at head may still issue in the flush cycle; the retained count is reduced accordingly.
- Commit arriving in the same cycle as a misbranch is ignored (the ROB never commits during its flush cycle).

Optional Feature:
- Macro: LSB_CDB_BYPASS_EN.
- Defined: on alloc, if Q1/Q2_from_dispatcher matches a same-cycle ALU/LSU broadcast, that CDB value is written and Qx=0.
- Undefined: the value is written as supplied, and the entry misses that broadcast. The dispatcher must then resolve it via its own ROB ready check.

Decomposition:
- The shared constant package holds: ROB_ID_TYPE (5 bits, ZERO_ROB=0), DATA_TYPE, ADDR_TYPE, LSB_SIZE, LSB_POS_TYPE, op encoding, IO_BASE.
- Sub-module lsb_operand_snoop: combinational match/update for one Q/V pair against two CDB ports; instantiated twice per entry.

Test Plan:
- Push load (Q1=0, V1=0x100, imm=4), lsu_busy=0 -> next edge enable_to_lsu=1, addr=0x104; count returns to 0.
- Push store (Q1=0, Q2=3); ALU broadcasts rob 3 = 0xAB; commit rob id -> store issues after commit with data=0xAB, never before.
- Push store(rob 1, committed), load(rob 2), load(rob 3); misbranch -> store issues; loads never issue; count=0 afterwards.
- Head load at addr 0x30004 (rob 5) -> io_ins_rob_id_to_rob=5, no issue until io_rob_id_from_rob=5, then issue in that cycle.
- Fill to LSB_SIZE-FULL_MARGIN -> full_signal=1. Wrap tail past 15 while alloc and issue fire in the same cycle -> ordering preserved.
- With LSB_CDB_BYPASS_EN, alloc Q1=7 while the ALU broadcasts rob 7 = 0x200 -> load issues next cycle with addr=0x200+imm.
